// File: rtl/pipelined_control_unit_pkg.sv
// Shared control-unit definitions: opcodes, ALU and writeback encodings, and the ID/EX bundle.
package ctrl_pkg;

  localparam int unsigned MaxGpioOut = 8;

  localparam logic [6:0] OpcReg    = 7'b0110011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  typedef enum logic [3:0] {
    AluAnd   = 4'b0000,
    AluOr    = 4'b0001,
    AluXor   = 4'b0010,
    AluAdd   = 4'b0011,
    AluSub   = 4'b0100,
    AluMul   = 4'b0101,
    AluMulh  = 4'b0110,
    AluMulhu = 4'b0111,
    AluSll   = 4'b1000,
    AluSrl   = 4'b1001,
    AluSra   = 4'b1010,
    AluSlt   = 4'b1100,
    AluSltu  = 4'b1101
  } aluop_e;

  typedef enum logic [1:0] {
    RegselAlu  = 2'b00,
    RegselCsr  = 2'b01,
    RegselUimm = 2'b10,
    RegselPc4  = 2'b11
  } regsel_e;

  // gpio_we is sized for the largest channel count; unused upper bits stay zero.
  typedef struct packed {
    logic                  valid;
    logic                  alusrc;
    logic                  regwrite;
    regsel_e               regsel;
    aluop_e                aluop;
    logic [4:0]            rd;
    logic [11:0]           csr_addr;
    logic                  csr_en;
    logic [MaxGpioOut-1:0] gpio_we;
    logic                  branch;
    logic                  jal;
    logic                  jalr;
    logic                  illegal;
  } ctrl_t;

endpackage

// File: rtl/pipelined_control_unit_if.sv
// ID-stage instruction handshake and registered EX-stage control bundle.
interface pipelined_control_unit_if #(
  parameter int unsigned NUM_GPIO_OUT = 2
);
  logic                    instr_valid;
  logic [31:0]             instr;
  logic                    stall;
  logic                    flush;
  logic                    ex_valid;
  logic                    ex_alusrc;
  logic                    ex_regwrite;
  logic [1:0]              ex_regsel;
  logic [3:0]              ex_aluop;
  logic [4:0]              ex_rd;
  logic [11:0]             ex_csr_addr;
  logic                    ex_csr_en;
  logic [NUM_GPIO_OUT-1:0] ex_gpio_we;
  logic                    ex_branch;
  logic                    ex_jal;
  logic                    ex_jalr;
  logic                    ex_illegal;
  logic                    ex_fwd_a;
  logic                    ex_fwd_b;

  modport master (
    output instr_valid, instr, stall, flush,
    input  ex_valid, ex_alusrc, ex_regwrite, ex_regsel, ex_aluop, ex_rd, ex_csr_addr,
           ex_csr_en, ex_gpio_we, ex_branch, ex_jal, ex_jalr, ex_illegal, ex_fwd_a, ex_fwd_b
  );

  modport slave (
    input  instr_valid, instr, stall, flush,
    output ex_valid, ex_alusrc, ex_regwrite, ex_regsel, ex_aluop, ex_rd, ex_csr_addr,
           ex_csr_en, ex_gpio_we, ex_branch, ex_jal, ex_jalr, ex_illegal, ex_fwd_a, ex_fwd_b
  );
endinterface

// File: rtl/pipelined_control_unit_decode.sv
// Combinational RV32 instruction decoder producing the ID/EX control bundle.
// Define MEXT_EN to decode MUL/MULH/MULHU.
module control_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_GPIO_OUT  = 2,
  parameter logic [11:0] GPIO_CSR_BASE = 12'hF02,
  parameter logic [3:0]  DEFAULT_ALUOP = 4'b0011
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        uses_rs1_o,
  output logic        uses_rs2_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       illegal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    ctrl_o          = '0;
    ctrl_o.valid    = 1'b1;
    ctrl_o.aluop    = aluop_e'(DEFAULT_ALUOP);
    ctrl_o.rd       = instr_i[11:7];
    ctrl_o.csr_addr = instr_i[31:20];
    uses_rs1_o      = 1'b0;
    uses_rs2_o      = 1'b0;
    illegal         = 1'b0;

    case (opcode)
      OpcReg: begin
        ctrl_o.regwrite = 1'b1;
        uses_rs1_o      = 1'b1;
        uses_rs2_o      = 1'b1;
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000:  ctrl_o.aluop = AluAdd;
              3'b001:  ctrl_o.aluop = AluSll;
              3'b010:  ctrl_o.aluop = AluSlt;
              3'b011:  ctrl_o.aluop = AluSltu;
              3'b100:  ctrl_o.aluop = AluXor;
              3'b101:  ctrl_o.aluop = AluSrl;
              3'b110:  ctrl_o.aluop = AluOr;
              default: ctrl_o.aluop = AluAnd;
            endcase
          end
          7'b0100000: begin
            case (funct3)
              3'b000:  ctrl_o.aluop = AluSub;
              3'b101:  ctrl_o.aluop = AluSra;
              default: illegal = 1'b1;
            endcase
          end
          7'b0000001: begin
`ifdef MEXT_EN
            case (funct3)
              3'b000:  ctrl_o.aluop = AluMul;
              3'b001:  ctrl_o.aluop = AluMulh;
              3'b011:  ctrl_o.aluop = AluMulhu;
              default: illegal = 1'b1;
            endcase
`else
            illegal = 1'b1;
`endif
          end
          default: illegal = 1'b1;
        endcase
      end
      OpcImm: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.regwrite = 1'b1;
        uses_rs1_o      = 1'b1;
        case (funct3)
          3'b000: ctrl_o.aluop = AluAdd;
          3'b001: ctrl_o.aluop = AluSll;
          3'b100: ctrl_o.aluop = AluXor;
          3'b110: ctrl_o.aluop = AluOr;
          3'b111: ctrl_o.aluop = AluAnd;
          3'b101: begin
            if (funct7 == 7'b0000000)      ctrl_o.aluop = AluSrl;
            else if (funct7 == 7'b0100000) ctrl_o.aluop = AluSra;
            else                           illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OpcLui: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regsel   = RegselUimm;
      end
      OpcBranch: begin
        ctrl_o.branch = 1'b1;
        uses_rs1_o    = 1'b1;
        uses_rs2_o    = 1'b1;
      end
      OpcJal: begin
        ctrl_o.jal      = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regsel   = RegselPc4;
      end
      OpcJalr: begin
        ctrl_o.jalr     = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regsel   = RegselPc4;
        uses_rs1_o      = 1'b1;
      end
      OpcSystem: begin
        if (funct3 == 3'b001) begin
          ctrl_o.csr_en   = 1'b1;
          ctrl_o.regwrite = 1'b1;
          ctrl_o.regsel   = RegselCsr;
          uses_rs1_o      = 1'b1;
          for (int unsigned k = 0; k < NUM_GPIO_OUT; k++) begin
            if (instr_i[31:20] == GPIO_CSR_BASE + 12'(k)) ctrl_o.gpio_we[k] = 1'b1;
          end
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase

    // Illegal encodings still occupy EX but must have no architectural side effects.
    if (illegal) begin
      ctrl_o.illegal  = 1'b1;
      ctrl_o.regwrite = 1'b0;
      ctrl_o.csr_en   = 1'b0;
      ctrl_o.gpio_we  = '0;
      ctrl_o.branch   = 1'b0;
      ctrl_o.jal      = 1'b0;
      ctrl_o.jalr     = 1'b0;
      ctrl_o.regsel   = RegselAlu;
      ctrl_o.aluop    = aluop_e'(DEFAULT_ALUOP);
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Registered control unit: ID decode captured into an ID/EX register with stall/flush/bubble
// handling and EX->EX operand forwarding selects. MEXT_EN enables the multiply decode.
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_GPIO_OUT  = 2,
  parameter logic [11:0] GPIO_CSR_BASE = 12'hF02,
  parameter logic [3:0]  DEFAULT_ALUOP = 4'b0011
) (
  input logic                     clk,
  input logic                     rst,
  pipelined_control_unit_if.slave bus
);

  ctrl_t dec_ctrl;
  ctrl_t ctrl_d, ctrl_q;
  logic  uses_rs1, uses_rs2;
  logic  ex_writes_reg;
  logic  fwd_a_d, fwd_a_q;
  logic  fwd_b_d, fwd_b_q;

  function automatic ctrl_t bubble();
    ctrl_t b;
    b       = '0;
    b.aluop = aluop_e'(DEFAULT_ALUOP);
    return b;
  endfunction

  control_decode #(
    .NUM_GPIO_OUT  (NUM_GPIO_OUT),
    .GPIO_CSR_BASE (GPIO_CSR_BASE),
    .DEFAULT_ALUOP (DEFAULT_ALUOP)
  ) u_decode (
    .instr_i    (bus.instr),
    .ctrl_o     (dec_ctrl),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2)
  );

  // x0 never hazards, so an EX writer to rd=0 never forwards.
  assign ex_writes_reg = ctrl_q.valid & ctrl_q.regwrite & (ctrl_q.rd != 5'd0);

  always_comb begin
    ctrl_d  = ctrl_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (bus.flush || (!bus.stall && !bus.instr_valid)) begin
      ctrl_d  = bubble();
      fwd_a_d = 1'b0;
      fwd_b_d = 1'b0;
    end else if (!bus.stall) begin
      ctrl_d  = dec_ctrl;
      fwd_a_d = uses_rs1 & ex_writes_reg & (bus.instr[19:15] == ctrl_q.rd);
      fwd_b_d = uses_rs2 & ex_writes_reg & (bus.instr[24:20] == ctrl_q.rd);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= bubble();
      fwd_a_q <= 1'b0;
      fwd_b_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign bus.ex_valid    = ctrl_q.valid;
  assign bus.ex_alusrc   = ctrl_q.alusrc;
  assign bus.ex_regwrite = ctrl_q.regwrite;
  assign bus.ex_regsel   = ctrl_q.regsel;
  assign bus.ex_aluop    = ctrl_q.aluop;
  assign bus.ex_rd       = ctrl_q.rd;
  assign bus.ex_csr_addr = ctrl_q.csr_addr;
  assign bus.ex_csr_en   = ctrl_q.csr_en;
  assign bus.ex_gpio_we  = ctrl_q.gpio_we[NUM_GPIO_OUT-1:0];
  assign bus.ex_branch   = ctrl_q.branch;
  assign bus.ex_jal      = ctrl_q.jal;
  assign bus.ex_jalr     = ctrl_q.jalr;
  assign bus.ex_illegal  = ctrl_q.illegal;
  assign bus.ex_fwd_a    = fwd_a_q;
  assign bus.ex_fwd_b    = fwd_b_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: table-driven decode model checked every cycle,
// plus hand-computed spot checks. Build with MEXT_EN to cover the multiply decode.
module tb_pipelined_control_unit;

  localparam int unsigned NG   = 4;
  localparam logic [11:0] BASE = 12'hF02;
`ifdef MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  localparam logic [31:0] ADDI5   = 32'h00700293;  // addi x5,x0,7
  localparam logic [31:0] ADD655  = 32'h00528333;  // add  x6,x5,x5
  localparam logic [31:0] ADDI0   = 32'h00700013;  // addi x0,x0,7
  localparam logic [31:0] ADD600  = 32'h00000333;  // add  x6,x0,x0
  localparam logic [31:0] SUB712  = 32'h402083B3;  // sub  x7,x1,x2
  localparam logic [31:0] OR312   = 32'h0020E1B3;  // or   x3,x1,x2
  localparam logic [31:0] SRAIBAD = 32'h0230D113;  // srai with funct7=0000001
  localparam logic [31:0] SRAI    = 32'h4030D113;  // srai x2,x1,3
  localparam logic [31:0] SLTI    = 32'h0020A093;  // slti (unsupported)
  localparam logic [31:0] MULHU   = 32'h023130B3;  // mulhu x1,x2,x3
  localparam logic [31:0] LUI3    = 32'h123451B7;  // lui  x3,0x12345
  localparam logic [31:0] JAL1    = 32'h008000EF;  // jal  x1,8
  localparam logic [31:0] JALR1   = 32'h000080E7;  // jalr x1,0(x1)
  localparam logic [31:0] BEQ12   = 32'h00208463;  // beq  x1,x2,8

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  pipelined_control_unit_if #(.NUM_GPIO_OUT(NG)) bus ();

  pipelined_control_unit #(
    .NUM_GPIO_OUT  (NG),
    .GPIO_CSR_BASE (BASE),
    .DEFAULT_ALUOP (4'b0011)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic          alusrc;
    logic          regwrite;
    logic [1:0]    regsel;
    logic [3:0]    aluop;
    logic [4:0]    rd;
    logic [11:0]   csr;
    logic          csr_en;
    logic [NG-1:0] gpio;
    logic          br;
    logic          jal;
    logic          jalr;
    logic          ill;
    logic          fa;
    logic          fb;
  } exp_t;

  // Legal encodings as mask/match rows: 0-12 R-type (10-12 multiply), 13-19 OP-IMM,
  // 20 LUI, 21 BRANCH, 22 JAL, 23 JALR, 24 CSRRW.
  localparam int NE = 25;
  localparam logic [31:0] TMASK [NE] = '{
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
    32'hFE00707F, 32'hFE00707F,
    32'h0000007F, 32'h0000007F, 32'h0000007F, 32'h0000007F, 32'h0000707F
  };
  localparam logic [31:0] TMATCH [NE] = '{
    32'h00000033, 32'h40000033, 32'h00007033, 32'h00006033, 32'h00004033,
    32'h00001033, 32'h00005033, 32'h40005033, 32'h00002033, 32'h00003033,
    32'h02000033, 32'h02001033, 32'h02003033,
    32'h00000013, 32'h00007013, 32'h00006013, 32'h00004013, 32'h00001013,
    32'h00005013, 32'h40005013,
    32'h00000037, 32'h00000063, 32'h0000006F, 32'h00000067, 32'h00001073
  };
  localparam logic [3:0] TALU [NE] = '{
    4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13,
    4'd5, 4'd6, 4'd7,
    4'd3, 4'd0, 4'd1, 4'd2, 4'd8, 4'd9, 4'd10,
    4'd3, 4'd3, 4'd3, 4'd3, 4'd3
  };

  function automatic exp_t empty_ex();
    exp_t e;
    e       = '0;
    e.aluop = 4'b0011;
    return e;
  endfunction

  function automatic exp_t mdl_next(input logic [31:0] ins, input exp_t prev);
    exp_t          e;
    int            hit;
    int            off;
    logic [6:0]    op;
    logic          u1;
    logic          u2;
    logic [NG-1:0] one;
    hit = -1;
    for (int i = 0; i < NE; i++) begin
      if (hit < 0 && (ins & TMASK[i]) == TMATCH[i] && (MEXT || i < 10 || i > 12)) hit = i;
    end
    op    = ins[6:0];
    u1    = (op inside {7'h33, 7'h13, 7'h63, 7'h67}) || (op == 7'h73 && ins[14:12] == 3'd1);
    u2    = op inside {7'h33, 7'h63};
    e     = empty_ex();
    e.valid = 1'b1;
    e.rd    = ins[11:7];
    e.csr   = ins[31:20];
    if (hit < 0) begin
      e.ill    = 1'b1;
      e.alusrc = (op == 7'h13);
    end else if (hit < 13) begin
      e.aluop    = TALU[hit];
      e.regwrite = 1'b1;
    end else if (hit < 20) begin
      e.aluop    = TALU[hit];
      e.alusrc   = 1'b1;
      e.regwrite = 1'b1;
    end else if (hit == 20) begin
      e.alusrc   = 1'b1;
      e.regwrite = 1'b1;
      e.regsel   = 2'b10;
    end else if (hit == 21) begin
      e.br = 1'b1;
    end else if (hit == 22) begin
      e.jal      = 1'b1;
      e.regwrite = 1'b1;
      e.regsel   = 2'b11;
    end else if (hit == 23) begin
      e.jalr     = 1'b1;
      e.alusrc   = 1'b1;
      e.regwrite = 1'b1;
      e.regsel   = 2'b11;
    end else begin
      e.csr_en   = 1'b1;
      e.regwrite = 1'b1;
      e.regsel   = 2'b01;
      off = int'(ins[31:20]) - int'(BASE);
      one = 1;
      if (off >= 0 && off < int'(NG)) e.gpio = one << off;
    end
    e.fa = u1 && prev.valid && prev.regwrite && prev.rd != 5'd0 && ins[19:15] == prev.rd;
    e.fb = u2 && prev.valid && prev.regwrite && prev.rd != 5'd0 && ins[24:20] == prev.rd;
    return e;
  endfunction

  exp_t m;
  exp_t got;

  always @(posedge clk or posedge rst) begin
    if (rst)                                           m <= empty_ex();
    else if (bus.flush)                                m <= empty_ex();
    else if (bus.stall)                                m <= m;
    else if (!bus.instr_valid)                         m <= empty_ex();
    else                                               m <= mdl_next(bus.instr, m);
  end

  assign got = {bus.ex_valid, bus.ex_alusrc, bus.ex_regwrite, bus.ex_regsel, bus.ex_aluop,
                bus.ex_rd, bus.ex_csr_addr, bus.ex_csr_en, bus.ex_gpio_we, bus.ex_branch,
                bus.ex_jal, bus.ex_jalr, bus.ex_illegal, bus.ex_fwd_a, bus.ex_fwd_b};

  always @(negedge clk) begin
    vectors = vectors + 1;
    if (got !== m) begin
      miscompares = miscompares + 1;
      $display("FAIL ex_bundle t=%0t got=%h exp=%h", $time, got, m);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] ins, input logic st, input logic fl);
    bus.instr_valid = v;
    bus.instr       = ins;
    bus.stall       = st;
    bus.flush       = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    rst             = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_aluop", 32'(bus.ex_aluop), 32'd3);
    chk("rst_regwrite", 32'(bus.ex_regwrite), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("idle_valid", 32'(bus.ex_valid), 32'd0);

    // Dependent pair, then stall holds the forwarding bits
    cyc(1'b1, ADDI5, 1'b0, 1'b0);
    chk("addi_alusrc", 32'(bus.ex_alusrc), 32'd1);
    chk("addi_rd", 32'(bus.ex_rd), 32'd5);
    cyc(1'b1, ADD655, 1'b0, 1'b0);
    chk("raw_fwd_a", 32'(bus.ex_fwd_a), 32'd1);
    chk("raw_fwd_b", 32'(bus.ex_fwd_b), 32'd1);
    chk("raw_aluop", 32'(bus.ex_aluop), 32'd3);
    chk("mdl_fwd_a", 32'(m.fa), 32'd1);
    cyc(1'b1, ADD655, 1'b1, 1'b0);
    chk("stall_fwd_a", 32'(bus.ex_fwd_a), 32'd1);

    // rd = x0 never forwards; a bubble in between clears the hazard
    cyc(1'b1, ADDI0, 1'b0, 1'b0);
    cyc(1'b1, ADD600, 1'b0, 1'b0);
    chk("x0_fwd_a", 32'(bus.ex_fwd_a), 32'd0);
    chk("x0_fwd_b", 32'(bus.ex_fwd_b), 32'd0);
    cyc(1'b1, ADDI5, 1'b0, 1'b0);
    cyc(1'b0, ADD655, 1'b0, 1'b0);
    cyc(1'b1, ADD655, 1'b0, 1'b0);
    chk("bubble_fwd_a", 32'(bus.ex_fwd_a), 32'd0);

    // Stall and flush
    cyc(1'b1, SUB712, 1'b0, 1'b0);
    chk("sub_aluop", 32'(bus.ex_aluop), 32'd4);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, OR312, 1'b1, 1'b0);
      chk("stall_aluop", 32'(bus.ex_aluop), 32'd4);
    end
    cyc(1'b1, OR312, 1'b1, 1'b1);
    chk("flush_stall_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_stall_aluop", 32'(bus.ex_aluop), 32'd3);
    cyc(1'b1, OR312, 1'b0, 1'b0);
    chk("or_aluop", 32'(bus.ex_aluop), 32'd1);
    cyc(1'b1, OR312, 1'b0, 1'b1);
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);

    // GPIO CSR window F02..F05
    cyc(1'b1, 32'hF04110F3, 1'b0, 1'b0);
    chk("gpio_f04", 32'(bus.ex_gpio_we), 32'h4);
    chk("csr_en_f04", 32'(bus.ex_csr_en), 32'd1);
    chk("regsel_csr", 32'(bus.ex_regsel), 32'd1);
    cyc(1'b1, 32'hF06110F3, 1'b0, 1'b0);
    chk("gpio_f06", 32'(bus.ex_gpio_we), 32'h0);
    chk("csr_en_f06", 32'(bus.ex_csr_en), 32'd1);
    cyc(1'b1, 32'hF02110F3, 1'b0, 1'b0);
    chk("gpio_f02", 32'(bus.ex_gpio_we), 32'h1);
    cyc(1'b1, 32'hF05110F3, 1'b0, 1'b0);
    chk("gpio_f05", 32'(bus.ex_gpio_we), 32'h8);
    cyc(1'b1, 32'hF01110F3, 1'b0, 1'b0);
    chk("gpio_f01", 32'(bus.ex_gpio_we), 32'h0);

    // Illegal encodings
    cyc(1'b1, 32'h0000007F, 1'b0, 1'b0);
    chk("ill7f_valid", 32'(bus.ex_valid), 32'd1);
    chk("ill7f_illegal", 32'(bus.ex_illegal), 32'd1);
    chk("ill7f_regwrite", 32'(bus.ex_regwrite), 32'd0);
    cyc(1'b1, SRAIBAD, 1'b0, 1'b0);
    chk("srai_bad_illegal", 32'(bus.ex_illegal), 32'd1);
    cyc(1'b1, SLTI, 1'b0, 1'b0);
    chk("slti_illegal", 32'(bus.ex_illegal), 32'd1);
    cyc(1'b1, SRAI, 1'b0, 1'b0);
    chk("srai_aluop", 32'(bus.ex_aluop), 32'd10);
    chk("srai_illegal", 32'(bus.ex_illegal), 32'd0);

    // Multiply extension
    cyc(1'b1, MULHU, 1'b0, 1'b0);
`ifdef MEXT_EN
    chk("mulhu_aluop", 32'(bus.ex_aluop), 32'd7);
    chk("mulhu_illegal", 32'(bus.ex_illegal), 32'd0);
`else
    chk("mulhu_illegal", 32'(bus.ex_illegal), 32'd1);
    chk("mulhu_regwrite", 32'(bus.ex_regwrite), 32'd0);
`endif

    // Control flow and forwarding through a link register
    cyc(1'b1, LUI3, 1'b0, 1'b0);
    chk("lui_regsel", 32'(bus.ex_regsel), 32'd2);
    cyc(1'b1, JAL1, 1'b0, 1'b0);
    chk("jal_regsel", 32'(bus.ex_regsel), 32'd3);
    chk("jal_flag", 32'(bus.ex_jal), 32'd1);
    cyc(1'b1, JALR1, 1'b0, 1'b0);
    chk("jalr_fwd_a", 32'(bus.ex_fwd_a), 32'd1);
    chk("jalr_fwd_b", 32'(bus.ex_fwd_b), 32'd0);
    cyc(1'b1, BEQ12, 1'b0, 1'b0);
    chk("beq_branch", 32'(bus.ex_branch), 32'd1);
    chk("beq_regwrite", 32'(bus.ex_regwrite), 32'd0);
    chk("beq_fwd_a", 32'(bus.ex_fwd_a), 32'd1);

    // Asynchronous reset mid-run, then idle until the next valid instruction
    cyc(1'b1, ADD655, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.ex_valid), 32'd0);
    chk("midrst_aluop", 32'(bus.ex_aluop), 32'd3);
    chk("midrst_rd", 32'(bus.ex_rd), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, ADD655, 1'b0, 1'b0);
      chk("postrst_valid", 32'(bus.ex_valid), 32'd0);
      chk("postrst_aluop", 32'(bus.ex_aluop), 32'd3);
    end
    cyc(1'b1, ADDI5, 1'b0, 1'b0);
    chk("postrst_load", 32'(bus.ex_valid), 32'd1);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
